mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Memory-side responder for the MIPS32 core's instruction port (ice/iaddr/idata) and data port (dce/daddr/we/din/dm), built as a unified on-chip word RAM. It also contains a boot-loader stream port and a small state machine. The state machine fills the RAM after reset, then releases the core's active-low reset. The block sits beside the CPU top in the SoC wrapper; the CPU connects to it with no extra glue.

## Interface
Parameters:
- ADDR_W, 10, word-address width; DEPTH = 2^ADDR_W words (default 4 KiB)
- LOAD_EN, 1, 1 = boot through the loader after reset; 0 = enter RUN directly

Ports:
- clk  in  1  single clock; every register updates on its rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- ice  in  1  instruction fetch enable
- iaddr  in  32  fetch byte address
- idata  out  32  fetched instruction (registered)
- dce  in  1  data access enable
- daddr  in  32  data byte address
- we  in  4  byte-lane write enables; we[3] → bits 31:24 … we[0] → bits 7:0
- din  in  32  write data, already lane-aligned by the CPU
- dm  out  32  read data (registered, full word)
- ld_valid  in  1  loader beat valid
- ld_ready  out  1  loader beat accepted when valid and ready are both high
- ld_data  in  32  loader word
- ld_last  in  1  marks the final loader beat
- ld_count  out  ADDR_W+1  number of words loaded
- cpu_rst_n  out  1  active-low reset driven to the CPU
- err  out  1  sticky flag for out-of-range access

## Operation
- Word index = addr[ADDR_W+1:2]. addr[1:0] is ignored.
- An address is out of range when addr[31:ADDR_W+2] is non-zero. Such a read returns 0. Such a write is dropped. Either sets err, which stays set until reset.
- States: LOAD, REL, RUN.
  - Reset enters LOAD when LOAD_EN=1, otherwise RUN.
- LOAD:
  - ld_ready = 1 (forced 0 while cpu_rst is high).
  - Each accepted beat writes ld_data to word ld_count, then ld_count increments.
  - A beat with ld_last, or the beat at ld_count = DEPTH-1, moves the FSM to REL.
  - CPU ports are ignored in LOAD: writes are dropped, reads return 0.
- REL: lasts exactly one cycle. ld_ready = 0 and cpu_rst_n = 0. Then go to RUN.
- RUN:
  - cpu_rst_n = 1 and ld_ready = 0.
  - A data write updates only the lanes whose we bit is set, when dce=1.
  - dce=1 with we=0 is a read.
  - ice=1 reads the word at iaddr.
  - RUN is left only by reset.
- ld_count stays at its final value in RUN.
- Both ports can access the RAM in the same cycle.
- Read-during-write to the same word returns the old word on dm and on idata (read-first).
- Reset does not clear RAM contents.

## Timing
- Read latency is 1 cycle on both ports.
  - idata and dm update on the edge after ice/dce is sampled.
  - This aligns idata with the core's ID stage and dm with its WB stage.
- When ice=0, idata holds its previous value. The same holds for dm when dce=0, or when the access is a write (we≠0).
- Writes commit on the sampling edge. A read of that word issued in the next cycle returns the new data.
- Reset values (during and after a cpu_rst cycle):
  - idata = 0, dm = 0, err = 0, ld_count = 0
  - cpu_rst_n = 0
  - ld_ready = 0 in the reset cycle itself
- After the final loader beat at edge N: state = REL at N (cpu_rst_n still 0), then RUN at N+1, so cpu_rst_n = 1 from N+1.
- With LOAD_EN=0: cpu_rst_n rises on the first edge with cpu_rst low.
- Reset mid-load: the FSM returns to LOAD with ld_count = 0. Words already written stay in the RAM.
- A loader beat presented together with reset is not accepted.
- ld_valid held high in RUN has no effect.

## Test plan
- Boot load: stream 4 words 0x11111111…0x44444444 with ld_last on the 4th beat. Expect ld_count = 4, one REL cycle, then cpu_rst_n = 1. Afterwards, ice reads of iaddr 0x0, 0x4, 0x8, 0xC return those words one cycle later.
- Byte lanes: word 0x10 holds 0xAABBCCDD. Write din = 0x11223344 with we = 4'b0101, then read the word. Expect dm = 0xAA22CC44.
- Read-first, same word on both ports: word 0x20 holds 0x5. Write 0x9 with we = 4'hF while ice reads 0x20 and a dm read is issued. Expect idata = 0x5 and dm = 0x5. The following read returns 0x9.
- Out of range (ADDR_W=10): write to daddr 0x00001000. Expect the write dropped and err = 1 from the next cycle. A read of 0x00001000 returns dm = 0. err stays 1 until cpu_rst.
- Reset mid-load: after 2 beats, assert cpu_rst for 1 cycle. Expect ld_count = 0, cpu_rst_n = 0, ld_ready = 0 during reset, ld_ready = 1 the cycle after. The earlier loaded words are still readable after the reload completes.
- Overflow and idle ports: with ADDR_W=2, stream 6 beats without ld_last. Expect REL after the 4th beat and ld_ready = 0 for beats 5-6. With ice=dce=0 in RUN, idata and dm hold their values.

Source files
------------

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: unified word RAM serving the MIPS32 instruction and
// data ports, with a boot-loader stream that fills the RAM after reset and
// then releases the core's active-low reset.

// One byte lane of the RAM: a single write port shared by the loader and the
// data port, plus two registered read-first read ports (fetch and data).
module mips_mem_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re_i,
  input  logic [ADDR_W-1:0] i_raddr_i,
  output logic [7:0]        o_rdata_i,
  input  logic              i_re_d,
  input  logic [ADDR_W-1:0] i_raddr_d,
  output logic [7:0]        o_rdata_d
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rd_i;
  logic [7:0] r_rd_d;

  // Byte write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Reads sample the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_re_i) r_rd_i <= r_mem[i_raddr_i];
    if (i_re_d) r_rd_d <= r_mem[i_raddr_d];
  end

  assign o_rdata_i = r_rd_i;
  assign o_rdata_d = r_rd_d;
endmodule

module mips_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter bit LOAD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            cpu_rst,
  input  logic            ice,
  input  logic [31:0]     iaddr,
  output logic [31:0]     idata,
  input  logic            dce,
  input  logic [31:0]     daddr,
  input  logic [3:0]      we,
  input  logic [31:0]     din,
  output logic [31:0]     dm,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic [ADDR_W:0] ld_count,
  output logic            cpu_rst_n,
  output logic            err
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              NUM_LANES = 4;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam state_t RST_STATE = (LOAD_EN != 1'b0) ? S_LOAD : S_RUN;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR_W:0] r_ld_count;
  logic            r_cpu_rst_n;
  logic            r_err;
  logic            r_i_ok;
  logic            r_d_ok;

  logic w_run;
  logic w_ld_ready;
  logic w_ld_fire;
  logic w_i_oor;
  logic w_d_oor;
  logic w_i_rd;
  logic w_d_rd;
  logic w_d_wr;
  logic w_unused;

  logic [NUM_LANES-1:0]      w_lane_we;
  logic [ADDR_W-1:0]         w_waddr;
  logic [31:0]               w_wdata;
  logic [NUM_LANES-1:0][7:0] w_i_lanes;
  logic [NUM_LANES-1:0][7:0] w_d_lanes;

  // Anything above the RAM's word index is an out-of-range access.
  assign w_i_oor = (iaddr >> (ADDR_W + 2)) != 32'd0;
  assign w_d_oor = (daddr >> (ADDR_W + 2)) != 32'd0;

  assign w_run      = (r_state == S_RUN);
  assign w_ld_ready = (r_state == S_LOAD) && !cpu_rst;
  assign w_ld_fire  = w_ld_ready && ld_valid;

  // CPU accesses only touch the RAM in RUN, in range, and outside reset.
  assign w_i_rd = w_run && !cpu_rst && ice && !w_i_oor;
  assign w_d_rd = w_run && !cpu_rst && dce && (we == 4'd0) && !w_d_oor;
  assign w_d_wr = w_run && !cpu_rst && dce && (we != 4'd0) && !w_d_oor;

  // Byte offset bits never select anything inside a word.
  assign w_unused = ^{iaddr[1:0], daddr[1:0]};

  // Single write port: loader owns it in LOAD, the data port in RUN.
  always_comb begin
    w_lane_we = '0;
    w_waddr   = r_ld_count[ADDR_W-1:0];
    w_wdata   = ld_data;
    if (w_ld_fire) begin
      w_lane_we = '1;
    end else if (w_d_wr) begin
      w_lane_we = we;
      w_waddr   = daddr[ADDR_W+1:2];
      w_wdata   = din;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mips_mem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk       (clk),
      .i_we      (w_lane_we[g]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata[8*g +: 8]),
      .i_re_i    (w_i_rd),
      .i_raddr_i (iaddr[ADDR_W+1:2]),
      .o_rdata_i (w_i_lanes[g]),
      .i_re_d    (w_d_rd),
      .i_raddr_d (daddr[ADDR_W+1:2]),
      .o_rdata_d (w_d_lanes[g])
    );
  end

  // Boot sequencing: LOAD until the last beat (or RAM full), one REL cycle, then RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD: if (w_ld_fire && (ld_last || (r_ld_count == LAST_IDX))) w_state_nxt = S_REL;
      S_REL:  w_state_nxt = S_RUN;
      S_RUN:  w_state_nxt = S_RUN;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // State register; the core's reset is released on the edge that enters RUN.
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_state     <= RST_STATE;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst_n <= (w_state_nxt == S_RUN);
    end
  end

  // Loader word counter, frozen once loading ends.
  always_ff @(posedge clk) begin
    if (cpu_rst)        r_ld_count <= '0;
    else if (w_ld_fire) r_ld_count <= r_ld_count + 1'b1;
  end

  // Sticky out-of-range flag, raised by either port while running.
  always_ff @(posedge clk) begin
    if (cpu_rst)
      r_err <= 1'b0;
    else if (w_run && ((ice && w_i_oor) || (dce && w_d_oor)))
      r_err <= 1'b1;
  end

  // Per-port "data is real" flags: cleared for out-of-range or non-RUN
  // reads so the output reads 0; held when the port is idle or writing.
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_i_ok <= 1'b0;
      r_d_ok <= 1'b0;
    end else begin
      if (ice)                    r_i_ok <= w_i_rd;
      if (dce && (we == 4'd0))    r_d_ok <= w_d_rd;
    end
  end

  assign idata     = r_i_ok ? w_i_lanes : 32'd0;
  assign dm        = r_d_ok ? w_d_lanes : 32'd0;
  assign ld_ready  = w_ld_ready;
  assign ld_count  = r_ld_count;
  assign cpu_rst_n = r_cpu_rst_n && !cpu_rst;
  assign err       = r_err;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed boot/lane/read-first/range/reset
// steps plus randomized RUN traffic against an array-based reference model.
module tb_mips_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cpu_rst;

  // Main DUT (ADDR_W=10, loader enabled)
  logic        ice, dce, ld_valid, ld_last;
  logic [31:0] iaddr, daddr, din, ld_data;
  logic [3:0]  we;
  logic [31:0] idata, dm;
  logic        ld_ready, cpu_rst_n, err;
  logic [10:0] ld_count;

  // Small DUT (ADDR_W=2) for the overflow case
  logic        b_ice, b_dce, b_ld_valid, b_ld_last;
  logic [31:0] b_iaddr, b_daddr, b_din, b_ld_data;
  logic [3:0]  b_we;
  logic [31:0] b_idata, b_dm;
  logic        b_ld_ready, b_cpu_rst_n, b_err;
  logic [2:0]  b_ld_count;

  // No-loader DUT sharing the main inputs
  logic [31:0] c_idata, c_dm;
  logic        c_ld_ready, c_cpu_rst_n, c_err;
  logic [10:0] c_ld_count;

  mips_mem_responder #(.ADDR_W(10), .LOAD_EN(1'b1)) u_dut (
    .clk(clk), .cpu_rst(cpu_rst), .ice(ice), .iaddr(iaddr), .idata(idata),
    .dce(dce), .daddr(daddr), .we(we), .din(din), .dm(dm),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_count(ld_count), .cpu_rst_n(cpu_rst_n), .err(err));

  mips_mem_responder #(.ADDR_W(2), .LOAD_EN(1'b1)) u_dut_b (
    .clk(clk), .cpu_rst(cpu_rst), .ice(b_ice), .iaddr(b_iaddr), .idata(b_idata),
    .dce(b_dce), .daddr(b_daddr), .we(b_we), .din(b_din), .dm(b_dm),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_count(b_ld_count), .cpu_rst_n(b_cpu_rst_n), .err(b_err));

  mips_mem_responder #(.ADDR_W(10), .LOAD_EN(1'b0)) u_dut_c (
    .clk(clk), .cpu_rst(cpu_rst), .ice(ice), .iaddr(iaddr), .idata(c_idata),
    .dce(dce), .daddr(daddr), .we(we), .din(din), .dm(c_dm),
    .ld_valid(ld_valid), .ld_ready(c_ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_count(c_ld_count), .cpu_rst_n(c_cpu_rst_n), .err(c_err));

  // Reference model of the main DUT: phase 0=loading, 1=release, 2=running.
  logic [31:0] m_mem [0:1023];
  int          m_phase, m_cnt;
  logic [31:0] m_idata, m_dm;
  logic        m_err, m_run;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply one clock edge's worth of the spec rules to the model.
  task automatic model_edge();
    int wi;
    if (cpu_rst) begin
      m_phase = 0; m_cnt = 0; m_idata = 0; m_dm = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (ice) m_idata = 0;
      if (dce && we == 4'd0) m_dm = 0;
      if (ld_valid) begin
        m_mem[m_cnt] = ld_data;
        m_cnt++;
        if (ld_last || m_cnt == 1024) m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ice) m_idata = 0;
      if (dce && we == 4'd0) m_dm = 0;
      m_phase = 2;
    end else begin
      if (ice) begin
        if (iaddr >= 32'h1000) begin m_idata = 0; m_err = 1; end
        else m_idata = m_mem[iaddr / 4];
      end
      if (dce) begin
        if (daddr >= 32'h1000) begin
          m_err = 1;
          if (we == 4'd0) m_dm = 0;
        end else if (we == 4'd0) begin
          m_dm = m_mem[daddr / 4];
        end else begin
          wi = int'(daddr / 4);
          for (int b = 0; b < 4; b++)
            if (we[b]) m_mem[wi][8*b +: 8] = din[8*b +: 8];
        end
      end
    end
    m_run = (m_phase == 2);
  endtask

  // One clock: update model, pass the edge, compare every main-DUT output.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("idata", idata, m_idata);
    chk("dm", dm, m_dm);
    chk("err", 32'(err), 32'(m_err));
    chk("ld_count", 32'(ld_count), 32'(m_cnt));
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_run && !cpu_rst));
    chk("ld_ready", 32'(ld_ready), 32'(m_phase == 0 && !cpu_rst));
  endtask

  initial begin
    cpu_rst = 1; ice = 0; dce = 0; we = 0; iaddr = 0; daddr = 0; din = 0;
    ld_valid = 0; ld_last = 0; ld_data = 0;
    b_ice = 0; b_dce = 0; b_we = 0; b_iaddr = 0; b_daddr = 0; b_din = 0;
    b_ld_valid = 0; b_ld_last = 0; b_ld_data = 0;
    m_phase = 0; m_cnt = 0; m_idata = 0; m_dm = 0; m_err = 0; m_run = 0;

    // Reset state
    step(); step();
    chk("rst_idata", idata, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("c_rst_n_in_reset", 32'(c_cpu_rst_n), 32'd0);
    cpu_rst = 0;
    step();
    chk("c_rst_n_first_edge", 32'(c_cpu_rst_n), 32'd1);
    chk("load_ready", 32'(ld_ready), 32'd1);

    // Boot load of 4 words
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = 32'(32'h11111111 * (i + 1)); ld_last = (i == 3);
      step();
    end
    ld_valid = 0; ld_last = 0;
    chk("boot_count", 32'(ld_count), 32'd4);
    chk("boot_rel_rst_n", 32'(cpu_rst_n), 32'd0);
    step();
    chk("boot_run_rst_n", 32'(cpu_rst_n), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ice = 1; iaddr = 32'(4 * i);
      step();
      chk("boot_fetch", idata, 32'(32'h11111111 * (i + 1)));
    end
    ice = 0;

    // Byte lanes
    dce = 1; daddr = 32'h10; we = 4'hF; din = 32'hAABBCCDD; step();
    we = 4'b0101; din = 32'h11223344; step();
    we = 4'h0; step();
    chk("byte_lanes", dm, 32'hAA22CC44);

    // Read-first on both ports
    daddr = 32'h20; we = 4'hF; din = 32'h5; step();
    we = 4'h0; step();
    chk("rf_pre_dm", dm, 32'h5);
    we = 4'hF; din = 32'h9; ice = 1; iaddr = 32'h20; step();
    chk("rf_idata_old", idata, 32'h5);
    chk("rf_dm_hold", dm, 32'h5);
    we = 4'h0; step();
    chk("rf_idata_new", idata, 32'h9);
    chk("rf_dm_new", dm, 32'h9);
    ice = 0;

    // Out of range
    daddr = 32'h1000; we = 4'hF; din = 32'hDEADBEEF; step();
    chk("oor_err_set", 32'(err), 32'd1);
    we = 4'h0; daddr = 32'h0; step();
    chk("oor_write_dropped", dm, 32'h11111111);
    daddr = 32'h1000; step();
    chk("oor_read_zero", dm, 32'd0);
    dce = 0; step();
    chk("oor_err_sticky", 32'(err), 32'd1);

    // Overflow on the 4-word instance
    for (int i = 0; i < 6; i++) begin
      b_ld_valid = 1; b_ld_data = 32'(32'hB00 + i);
      if (i >= 4) chk("b_ready_low_extra_beat", 32'(b_ld_ready), 32'd0);
      step();
      if (i == 3) begin
        chk("b_count_full", 32'(b_ld_count), 32'd4);
        chk("b_rel_rst_n", 32'(b_cpu_rst_n), 32'd0);
      end
      if (i == 4) chk("b_run_rst_n", 32'(b_cpu_rst_n), 32'd1);
    end
    b_ld_valid = 0;
    chk("b_count_final", 32'(b_ld_count), 32'd4);
    b_ice = 1; b_iaddr = 32'h4; b_dce = 1; b_daddr = 32'h8; step();
    chk("b_idata", b_idata, 32'hB01);
    chk("b_dm", b_dm, 32'hB02);
    b_ice = 0; b_dce = 0; b_iaddr = 32'hC; b_daddr = 32'h0; step(); step();
    chk("b_idata_hold", b_idata, 32'hB01);
    chk("b_dm_hold", b_dm, 32'hB02);
    b_dce = 1; step();
    chk("b_word0_not_overwritten", b_dm, 32'hB00);
    b_daddr = 32'h10; step();
    chk("b_oor_read", b_dm, 32'd0);
    chk("b_oor_err", 32'(b_err), 32'd1);
    b_dce = 0;

    // Reset mid-load
    cpu_rst = 1; step();
    chk("c_rst_n_reset_again", 32'(c_cpu_rst_n), 32'd0);
    cpu_rst = 0; ld_valid = 1; ld_data = 32'hB0; step();
    ld_data = 32'hB1; step();
    cpu_rst = 1; ld_data = 32'hB2; step();
    chk("mid_count_zero", 32'(ld_count), 32'd0);
    chk("mid_rst_n_low", 32'(cpu_rst_n), 32'd0);
    chk("mid_ready_in_reset", 32'(ld_ready), 32'd0);
    cpu_rst = 0; ld_valid = 0;
    #1;
    chk("mid_ready_after", 32'(ld_ready), 32'd1);
    ld_valid = 1; ld_data = 32'hC0; ld_last = 1; step();
    ld_valid = 0; ld_last = 0; step();
    dce = 1; daddr = 32'h4; ice = 1; iaddr = 32'h0; step();
    chk("mid_word1_kept", dm, 32'hB1);
    chk("mid_word0_reload", idata, 32'hC0);
    daddr = 32'h8; step();
    chk("mid_word2_kept", dm, 32'h33333333);
    ice = 0; dce = 0;

    // Randomized RUN traffic over words 0..63 with occasional out-of-range
    dce = 1; we = 4'hF;
    for (int w = 0; w < 64; w++) begin
      daddr = 32'(4 * w); din = $urandom; step();
    end
    for (int n = 0; n < 400; n++) begin
      ice   = 1'($urandom_range(0, 1));
      dce   = 1'($urandom_range(0, 1));
      iaddr = ($urandom_range(0, 31) == 0) ? ($urandom | 32'h1000)
                                           : 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      daddr = ($urandom_range(0, 31) == 0) ? ($urandom | 32'h1000)
                                           : 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      din   = $urandom;
      step();
    end
    ice = 0; dce = 0; we = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
